ct_fadd_norm_shift_pipe: RTL and testbench
==========================================

// Module: ct_fadd_norm_shift_pipe
// PURPOSE
//  Parametrised, pipelined one-hot-controlled normalisation left-shifter for the vfalu adder datapath.
//  Leading-one position arrives one-hot; the block shifts the mantissa so that one lands in the MSB.
//  Also returns the encoded shift amount, zero and error flags.
//  Two registered stages with valid/ready flow control; sits between the LZA and the exponent-adjust/round stage.
// PARAMETERS
//  WIDTH  12  mantissa/one-hot width (>=2)
//  SHW    4   shift-amount width; must satisfy 2**SHW > WIDTH
// PORTS
//  forever_cpuclk  in   1      clock; all state on rising edge
//  cpurst          in   1      synchronous reset, active-high
//  flush           in   1      sync flush: discard all in-flight entries
//  in_vld          in   1      input valid
//  in_rdy          out  1      input ready; transfer when in_vld & in_rdy
//  in_data         in   WIDTH  unnormalised mantissa
//  in_onehot       in   WIDTH  leading-one position, one-hot or zero
//  out_vld         out  1      output valid
//  out_rdy         in   1      downstream ready; transfer when out_vld & out_rdy
//  out_result      out  WIDTH  normalised mantissa
//  out_shamt       out  SHW    left-shift amount applied
//  out_zero        out  1      in_onehot was all-zero
//  out_err         out  1      in_onehot had >1 bit set (only with the CHK macro)
// BEHAVIOUR
//  - One clock domain (forever_cpuclk); reset synchronous, active-high (cpurst).
//  - Reset: s1_vld=s2_vld=0; all stage data regs 0.
//    After reset out_vld=0, out_result=0, out_shamt=0, out_zero=0, out_err=0, in_rdy=1.
//  - Stage 1 (on accept): registers in_data; encodes in_onehot to shamt.
//    Bit k set -> shamt = WIDTH-1-k. Zero one-hot -> shamt = WIDTH, zero=1.
//  - Stage 2: result = (s1_data << s1_shamt) truncated to WIDTH, zero-filled from the LSB.
//    Zero one-hot -> result = 0.
//  - Latency: 2 cycles from accept to out_vld. Throughput 1/cycle when out_rdy=1.
//  - Flow control:
//      s2_adv = s1_vld & (~s2_vld | out_rdy)
//      in_rdy = ~flush & (~s1_vld | s2_adv)
//      s2_vld clears on out handshake unless s2_adv.
//  - Stalled stages hold data and flags unchanged. Outputs are driven directly from stage-2 registers.
//  - Accept and drain in the same cycle are legal; no bubble and no loss.
//  - flush: next edge s1_vld=s2_vld=0, data regs untouched; in_rdy=0 during the flush cycle.
//    flush dominates a simultaneous handshake.
//  - cpurst mid-operation: same as flush, plus data regs cleared; in-flight entries are lost by design.
//  - No ordering change: entries leave strictly in acceptance order.
// CONFIGURATION
//  CT_FADD_NORM_ONEHOT_CHK_EN defined:
//    - Stage 1 flags popcount(in_onehot)>1: err=1, result forced 0, shamt 0, zero 0.
//  CT_FADD_NORM_ONEHOT_CHK_EN undefined:
//    - No check; out_err tied 0.
//    - Multi-hot input gives the AND-OR mux value: OR of data<<(WIDTH-1-k) over set bits k.
//    - shamt is the OR of the per-bit encodings.
// TESTING
//  1 WIDTH=12, data 0x0AB, onehot 0x080, out_rdy=1
//    -> 2 cycles later out_result 0xAB0, shamt 4, zero 0.
//  2 onehot 0x000, data 0xFFF -> out_result 0x000, shamt 12, zero 1.
//  3 onehot 0x800 / 0x001 with data 0x801 -> result 0x801 shamt 0; result 0x800 shamt 11.
//  4 Backpressure:
//      3 back-to-back inputs, out_rdy=0 for 4 cycles -> in_rdy=0 once both stages are full.
//      On release, all 3 exit in order, none lost or duplicated.
//  5 Multi-hot 0x0C0, data 0x0AB -> with macro: err 1, result 0x000.
//    Without macro: result 0xFF0, err 0.
//  6 flush with 2 entries in flight plus in_vld=1 -> next cycle out_vld 0, input not accepted.
//    Repeat with cpurst: all outputs 0.
//  7 WIDTH=24, SHW=5, onehot bit0, data 0x000001 -> result 0x800000, shamt 23.

Source files
------------

// File: rtl/ct_fadd_norm_shift_pipe.sv
// Two-stage normalisation left-shifter: a one-hot leading-one position selects the shift that moves it to the MSB.
// Optional macro CT_FADD_NORM_ONEHOT_CHK_EN flags multi-hot leading-one vectors as errors.
module ct_fadd_norm_shift_pipe #(
  parameter int WIDTH = 12,
  parameter int SHW   = 4
) (
  input  logic             forever_cpuclk,
  input  logic             cpurst,
  input  logic             flush,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [WIDTH-1:0] in_data,
  input  logic [WIDTH-1:0] in_onehot,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [WIDTH-1:0] out_result,
  output logic [SHW-1:0]   out_shamt,
  output logic             out_zero,
  output logic             out_err
);

  logic             s1_vld_reg, s2_vld_reg;
  logic [WIDTH-1:0] s1_data_reg, s1_onehot_reg;
  logic [SHW-1:0]   s1_shamt_reg;
  logic             s1_zero_reg;
  logic [WIDTH-1:0] s2_result_reg;
  logic [SHW-1:0]   s2_shamt_reg;
  logic             s2_zero_reg;

  logic             s2_adv, accept;
  logic             oh_zero;
  logic [SHW-1:0]   enc_or;
  logic [WIDTH-1:0] mux_or;
  logic [SHW-1:0]   s1_shamt_next;
  logic             s1_zero_next;
  logic [WIDTH-1:0] s1_onehot_next;

  logic [SHW-1:0]   enc_terms [WIDTH];
  logic [WIDTH-1:0] mux_terms [WIDTH];

  assign s2_adv = s1_vld_reg & (~s2_vld_reg | out_rdy);
  assign in_rdy = ~flush & (~s1_vld_reg | s2_adv);
  assign accept = in_vld & in_rdy;

  // Per-bit shift encodings and AND-OR shifted data; multi-hot vectors OR together
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    assign enc_terms[gi] = in_onehot[gi] ? SHW'(WIDTH - 1 - gi) : '0;
    assign mux_terms[gi] = s1_onehot_reg[gi] ? (s1_data_reg << (WIDTH - 1 - gi)) : '0;
  end

  always_comb begin
    enc_or = '0;
    mux_or = '0;
    for (int k = 0; k < WIDTH; k++) begin
      enc_or = enc_or | enc_terms[k];
      mux_or = mux_or | mux_terms[k];
    end
  end

  assign oh_zero = (in_onehot == '0);

`ifdef CT_FADD_NORM_ONEHOT_CHK_EN
  logic oh_multi;
  logic s1_err_next, s1_err_reg, s2_err_reg;
  assign oh_multi = |(in_onehot & (in_onehot - WIDTH'(1)));
`endif

  always_comb begin
    s1_shamt_next  = oh_zero ? SHW'(WIDTH) : enc_or;
    s1_zero_next   = oh_zero;
    s1_onehot_next = in_onehot;
`ifdef CT_FADD_NORM_ONEHOT_CHK_EN
    s1_err_next = 1'b0;
    // A cleared one-hot makes the stage-2 mux produce zero
    if (oh_multi) begin
      s1_err_next    = 1'b1;
      s1_shamt_next  = '0;
      s1_zero_next   = 1'b0;
      s1_onehot_next = '0;
    end
`endif
  end

  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      s1_vld_reg    <= 1'b0;
      s2_vld_reg    <= 1'b0;
      s1_data_reg   <= '0;
      s1_onehot_reg <= '0;
      s1_shamt_reg  <= '0;
      s1_zero_reg   <= 1'b0;
      s2_result_reg <= '0;
      s2_shamt_reg  <= '0;
      s2_zero_reg   <= 1'b0;
`ifdef CT_FADD_NORM_ONEHOT_CHK_EN
      s1_err_reg    <= 1'b0;
      s2_err_reg    <= 1'b0;
`endif
    end else begin
      if (flush) begin
        s1_vld_reg <= 1'b0;
        s2_vld_reg <= 1'b0;
      end else begin
        if (accept)      s1_vld_reg <= 1'b1;
        else if (s2_adv) s1_vld_reg <= 1'b0;
        if (s2_adv)       s2_vld_reg <= 1'b1;
        else if (out_rdy) s2_vld_reg <= 1'b0;
      end
      if (accept) begin
        s1_data_reg   <= in_data;
        s1_onehot_reg <= s1_onehot_next;
        s1_shamt_reg  <= s1_shamt_next;
        s1_zero_reg   <= s1_zero_next;
`ifdef CT_FADD_NORM_ONEHOT_CHK_EN
        s1_err_reg    <= s1_err_next;
`endif
      end
      if (s2_adv && !flush) begin
        s2_result_reg <= mux_or;
        s2_shamt_reg  <= s1_shamt_reg;
        s2_zero_reg   <= s1_zero_reg;
`ifdef CT_FADD_NORM_ONEHOT_CHK_EN
        s2_err_reg    <= s1_err_reg;
`endif
      end
    end
  end

  assign out_vld    = s2_vld_reg;
  assign out_result = s2_result_reg;
  assign out_shamt  = s2_shamt_reg;
  assign out_zero   = s2_zero_reg;
`ifdef CT_FADD_NORM_ONEHOT_CHK_EN
  assign out_err    = s2_err_reg;
`else
  assign out_err    = 1'b0;
`endif

endmodule

// File: tb/tb_ct_fadd_norm_shift_pipe.sv
// Directed bench for ct_fadd_norm_shift_pipe: WIDTH=12 instance plus a WIDTH=24 instance.
module tb_ct_fadd_norm_shift_pipe;

  logic        forever_cpuclk = 1'b0;
  logic        cpurst = 1'b1;
  logic        flush = 1'b0;
  logic        in_vld = 1'b0;
  logic        in_rdy;
  logic [11:0] in_data = '0;
  logic [11:0] in_onehot = '0;
  logic        out_vld;
  logic        out_rdy = 1'b1;
  logic [11:0] out_result;
  logic [3:0]  out_shamt;
  logic        out_zero;
  logic        out_err;

  logic        flush24 = 1'b0;
  logic        in_vld24 = 1'b0;
  logic        in_rdy24;
  logic [23:0] in_data24 = '0;
  logic [23:0] in_onehot24 = '0;
  logic        out_vld24;
  logic        out_rdy24 = 1'b1;
  logic [23:0] out_result24;
  logic [4:0]  out_shamt24;
  logic        out_zero24;
  logic        out_err24;

  int checks = 0;
  int errors = 0;

  always #5 forever_cpuclk = ~forever_cpuclk;

  ct_fadd_norm_shift_pipe #(.WIDTH(12), .SHW(4)) u_dut (
    .forever_cpuclk(forever_cpuclk), .cpurst(cpurst), .flush(flush),
    .in_vld(in_vld), .in_rdy(in_rdy), .in_data(in_data), .in_onehot(in_onehot),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_result(out_result),
    .out_shamt(out_shamt), .out_zero(out_zero), .out_err(out_err)
  );

  ct_fadd_norm_shift_pipe #(.WIDTH(24), .SHW(5)) u_dut24 (
    .forever_cpuclk(forever_cpuclk), .cpurst(cpurst), .flush(flush24),
    .in_vld(in_vld24), .in_rdy(in_rdy24), .in_data(in_data24), .in_onehot(in_onehot24),
    .out_vld(out_vld24), .out_rdy(out_rdy24), .out_result(out_result24),
    .out_shamt(out_shamt24), .out_zero(out_zero24), .out_err(out_err24)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge forever_cpuclk);
    #1;
  endtask

  // One isolated transaction with out_rdy=1; checks 2-cycle latency and single-cycle presence
  task automatic run_single(input string tag, input logic [11:0] d, input logic [11:0] oh,
                            input logic [11:0] eres, input logic [3:0] esh,
                            input logic ezero, input logic eerr);
    in_data = d; in_onehot = oh; in_vld = 1'b1; out_rdy = 1'b1;
    tick();
    in_vld = 1'b0;
    chk({tag, "_lat1_vld"}, 32'(out_vld), 32'd0);
    tick();
    chk({tag, "_vld"}, 32'(out_vld), 32'd1);
    chk({tag, "_result"}, 32'(out_result), 32'(eres));
    chk({tag, "_shamt"}, 32'(out_shamt), 32'(esh));
    chk({tag, "_zero"}, 32'(out_zero), 32'(ezero));
    chk({tag, "_err"}, 32'(out_err), 32'(eerr));
    $display("txn %s data=0x%03h onehot=0x%03h -> result=0x%03h shamt=%0d zero=%0d err=%0d",
             tag, d, oh, out_result, out_shamt, out_zero, out_err);
    tick();
    chk({tag, "_drained"}, 32'(out_vld), 32'd0);
  endtask

  initial begin
    tick();
    tick();
    cpurst = 1'b0;
    #1;
    chk("rst_out_vld", 32'(out_vld), 32'd0);
    chk("rst_result", 32'(out_result), 32'd0);
    chk("rst_shamt", 32'(out_shamt), 32'd0);
    chk("rst_zero", 32'(out_zero), 32'd0);
    chk("rst_err", 32'(out_err), 32'd0);
    chk("rst_in_rdy", 32'(in_rdy), 32'd1);
    chk("rst_out_vld24", 32'(out_vld24), 32'd0);

    run_single("t1", 12'h0AB, 12'h080, 12'hAB0, 4'd4, 1'b0, 1'b0);
    run_single("t2", 12'hFFF, 12'h000, 12'h000, 4'd12, 1'b1, 1'b0);
    run_single("t3a", 12'h801, 12'h800, 12'h801, 4'd0, 1'b0, 1'b0);
    run_single("t3b", 12'h801, 12'h001, 12'h800, 4'd11, 1'b0, 1'b0);
`ifdef CT_FADD_NORM_ONEHOT_CHK_EN
    run_single("t5", 12'h0AB, 12'h0C0, 12'h000, 4'd0, 1'b0, 1'b1);
`else
    run_single("t5", 12'h0AB, 12'h0C0, 12'hFF0, 4'd5, 1'b0, 1'b0);
`endif

    // Backpressure: A, B, C offered back to back while out_rdy=0 for 4 cycles
    out_rdy = 1'b0;
    in_vld = 1'b1; in_data = 12'h0AB; in_onehot = 12'h080;
    tick();
    chk("bp_rdy_after_A", 32'(in_rdy), 32'd1);
    in_data = 12'h801; in_onehot = 12'h800;
    tick();
    chk("bp_rdy_full", 32'(in_rdy), 32'd0);
    chk("bp_vld_A", 32'(out_vld), 32'd1);
    in_data = 12'h801; in_onehot = 12'h001;
    tick();
    chk("bp_rdy_full2", 32'(in_rdy), 32'd0);
    tick();
    chk("bp_hold_A", 32'(out_result), 32'hAB0);
    chk("bp_hold_A_shamt", 32'(out_shamt), 32'd4);
    out_rdy = 1'b1;
    #1;
    chk("bp_rdy_release", 32'(in_rdy), 32'd1);
    tick();
    in_vld = 1'b0;
    chk("bp_B_vld", 32'(out_vld), 32'd1);
    chk("bp_B_result", 32'(out_result), 32'h801);
    chk("bp_B_shamt", 32'(out_shamt), 32'd0);
    $display("txn bp_B result=0x%03h shamt=%0d", out_result, out_shamt);
    tick();
    chk("bp_C_vld", 32'(out_vld), 32'd1);
    chk("bp_C_result", 32'(out_result), 32'h800);
    chk("bp_C_shamt", 32'(out_shamt), 32'd11);
    $display("txn bp_C result=0x%03h shamt=%0d", out_result, out_shamt);
    tick();
    chk("bp_drained", 32'(out_vld), 32'd0);

    // Flush with two entries in flight and a new input offered
    out_rdy = 1'b0;
    in_vld = 1'b1; in_data = 12'h0AB; in_onehot = 12'h080;
    tick();
    in_data = 12'h801; in_onehot = 12'h800;
    tick();
    in_data = 12'h123; in_onehot = 12'h100;
    flush = 1'b1;
    #1;
    chk("fl_in_rdy", 32'(in_rdy), 32'd0);
    tick();
    flush = 1'b0; in_vld = 1'b0; out_rdy = 1'b1;
    chk("fl_out_vld", 32'(out_vld), 32'd0);
    chk("fl_data_kept", 32'(out_result), 32'hAB0);
    tick();
    chk("fl_no_accept", 32'(out_vld), 32'd0);
    tick();
    chk("fl_empty", 32'(out_vld), 32'd0);
    $display("txn flush out_vld=%0d result=0x%03h", out_vld, out_result);

    // Same scenario with cpurst: all outputs return to zero
    out_rdy = 1'b0;
    in_vld = 1'b1; in_data = 12'hFFF; in_onehot = 12'h000;
    tick();
    in_data = 12'h801; in_onehot = 12'h800;
    tick();
    chk("rs_pre_zero", 32'(out_zero), 32'd1);
    in_data = 12'h123; in_onehot = 12'h100;
    cpurst = 1'b1;
    tick();
    cpurst = 1'b0; in_vld = 1'b0; out_rdy = 1'b1;
    chk("rs_out_vld", 32'(out_vld), 32'd0);
    chk("rs_result", 32'(out_result), 32'd0);
    chk("rs_shamt", 32'(out_shamt), 32'd0);
    chk("rs_zero", 32'(out_zero), 32'd0);
    chk("rs_err", 32'(out_err), 32'd0);
    tick();
    chk("rs_no_accept", 32'(out_vld), 32'd0);
    $display("txn reset out_vld=%0d result=0x%03h shamt=%0d", out_vld, out_result, out_shamt);

    // WIDTH=24 instance: leading one at bit 0
    in_vld24 = 1'b1; in_data24 = 24'h000001; in_onehot24 = 24'h000001;
    tick();
    in_vld24 = 1'b0;
    tick();
    chk("w24_vld", 32'(out_vld24), 32'd1);
    chk("w24_result", 32'(out_result24), 32'h800000);
    chk("w24_shamt", 32'(out_shamt24), 32'd23);
    chk("w24_zero", 32'(out_zero24), 32'd0);
    $display("txn w24 result=0x%06h shamt=%0d", out_result24, out_shamt24);
    tick();
    chk("w24_drained", 32'(out_vld24), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
